// File: rtl/rover_pkg.sv
// Shared H-bridge encodings, direction codes and scheduler state type.
package rover_pkg;

  localparam logic [3:0] HB_STOP  = 4'b0000;
  localparam logic [3:0] HB_LEFT  = 4'b1010;
  localparam logic [3:0] HB_RIGHT = 4'b0101;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BRAKE,
    ST_TURN,
    ST_SETTLE,
    ST_DONE
  } state_t;

  function automatic logic [3:0] turn_pattern(input logic dir);
    logic [3:0] pat;
    case (dir)
      DIR_LEFT:  pat = HB_LEFT;
      DIR_RIGHT: pat = HB_RIGHT;
      default:   pat = HB_STOP;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Phase down-counter: load (length - 1) on phase entry, count down to zero and hold there.
// zero is high on the last clock of the phase; load has priority over the decrement.
module turn_timer #(
  parameter int CNT_W = 28
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/turn_scheduler.sv
// Arbitrates two turn requesters and runs brake/turn/settle/done manoeuvres on the H-bridge.
// Optional TURN_PWM_EN: PWM-modulates the turn pattern with turn_duty; default build drives it fully on.
module turn_scheduler
  import rover_pkg::*;
#(
  parameter int CNT_W         = 28,
  parameter int BRAKE_CYCLES  = 5000000,
  parameter int SHORT_CYCLES  = 20000000,
  parameter int LONG_CYCLES   = 40000000,
  parameter int SETTLE_CYCLES = 5000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] drive_cmd,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_dir,
  input  logic [1:0] req_long,
  output logic [1:0] req_ready,
  input  logic       abort,
  input  logic [7:0] turn_duty,
  output logic [3:0] h_bridge,
  output logic       busy,
  output logic       turning_long,
  output logic       turn_done
);

  localparam logic [CNT_W-1:0] BRAKE_LD  = CNT_W'(BRAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHORT_LD  = CNT_W'(SHORT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LD   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic             long_q, long_d;
  logic [3:0]       h_bridge_q, h_bridge_d;
  logic [1:0]       req_ready_q, req_ready_d;
  logic             turning_long_q, turning_long_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             turn_on;

  turn_timer #(.CNT_W(CNT_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    long_d      = long_q;
    req_ready_d = 2'b00;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid[0]) begin
          req_ready_d = 2'b01;
          dir_d       = req_dir[0];
          long_d      = req_long[0];
        end else if (req_valid[1]) begin
          req_ready_d = 2'b10;
          dir_d       = req_dir[1];
          long_d      = req_long[1];
        end
        if (req_ready_d != 2'b00) begin
          state_d  = ST_BRAKE;
          tmr_load = 1'b1;
          tmr_val  = BRAKE_LD;
        end
      end
      ST_BRAKE: begin
        // abort outranks a same-edge expiry so SETTLE always starts with a full timer
        if (abort) begin
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end else if (tmr_zero) begin
          state_d  = ST_TURN;
          tmr_load = 1'b1;
          tmr_val  = long_q ? LONG_LD : SHORT_LD;
        end
      end
      ST_TURN: begin
        if (abort || tmr_zero) begin
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef TURN_PWM_EN
  logic [7:0] pwm_cnt_q, pwm_cnt_d;

  // Counter value that will be live in the next TURN cycle; zero on entry.
  always_comb begin
    pwm_cnt_d = 8'd0;
    if (state_d == ST_TURN && state_q == ST_TURN) begin
      pwm_cnt_d = pwm_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pwm_cnt_q <= 8'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign turn_on = (pwm_cnt_d < turn_duty);
`else
  logic unused_duty;
  assign unused_duty = ^turn_duty;
  assign turn_on     = 1'b1;
`endif

  // Outputs are registered from the next state so the pins change on the transition edge.
  always_comb begin
    h_bridge_d     = HB_STOP;
    turning_long_d = 1'b0;
    case (state_d)
      ST_IDLE: h_bridge_d = drive_cmd;
      ST_TURN: begin
        h_bridge_d     = turn_on ? turn_pattern(dir_d) : HB_STOP;
        turning_long_d = long_d;
      end
      default: h_bridge_d = HB_STOP;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      dir_q          <= 1'b0;
      long_q         <= 1'b0;
      h_bridge_q     <= HB_STOP;
      req_ready_q    <= 2'b00;
      turning_long_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_d;
      long_q         <= long_d;
      h_bridge_q     <= h_bridge_d;
      req_ready_q    <= req_ready_d;
      turning_long_q <= turning_long_d;
    end
  end

  assign h_bridge     = h_bridge_q;
  assign req_ready    = req_ready_q;
  assign turning_long = turning_long_q;
  assign busy         = (state_q != ST_IDLE);
  assign turn_done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler with short phase lengths (brake 4, short 10, long 20, settle 3).
module tb_turn_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] drive_cmd;
  logic [1:0] req_valid, req_dir, req_long, req_ready;
  logic       abort;
  logic [7:0] turn_duty;
  logic [3:0] h_bridge;
  logic       busy, turning_long, turn_done;

  int n_checks = 0;
  int n_fail   = 0;

  turn_scheduler #(
    .CNT_W(28), .BRAKE_CYCLES(4), .SHORT_CYCLES(10), .LONG_CYCLES(20), .SETTLE_CYCLES(3)
  ) dut (
    .clock(clock), .reset(reset), .drive_cmd(drive_cmd), .req_valid(req_valid),
    .req_dir(req_dir), .req_long(req_long), .req_ready(req_ready), .abort(abort),
    .turn_duty(turn_duty), .h_bridge(h_bridge), .busy(busy),
    .turning_long(turning_long), .turn_done(turn_done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks n consecutive in-manoeuvre cycles, advancing one clock after each.
  task automatic hold(input string tag, input int n, input logic [3:0] h, input logic tl);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_h"}, 32'(h_bridge), 32'(h));
      chk({tag, "_tl"}, 32'(turning_long), 32'(tl));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done"}, 32'(turn_done), 32'd0);
      chk({tag, "_rdy"}, 32'(req_ready), 32'd0);
      tick();
    end
  endtask

  task automatic finish_done(input string tag, input logic [3:0] idle_h);
    chk({tag, "_done"}, 32'(turn_done), 32'd1);
    chk({tag, "_done_h"}, 32'(h_bridge), 32'h0);
    chk({tag, "_done_busy"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_idle_done"}, 32'(turn_done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_h"}, 32'(h_bridge), 32'(idle_h));
  endtask

  initial begin
    reset = 1'b0; drive_cmd = 4'b1001; req_valid = 2'b00; req_dir = 2'b00;
    req_long = 2'b00; abort = 1'b0; turn_duty = 8'hFF;

    // 1: reset and passthrough
    tick(); tick(); tick();
    chk("rst_h", 32'(h_bridge), 32'h0);
    chk("rst_rdy", 32'(req_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tl", 32'(turning_long), 32'd0);
    chk("rst_done", 32'(turn_done), 32'd0);
    reset = 1'b1;
    tick();
    chk("pass_h", 32'(h_bridge), 32'h9);
    chk("pass_busy", 32'(busy), 32'd0);
    drive_cmd = 4'b0110;
    #1;
    chk("pass_latency", 32'(h_bridge), 32'h9);
    tick();
    chk("pass_h2", 32'(h_bridge), 32'h6);

    // 2: requester 0, right short; inputs changed after accept must be ignored
    req_valid = 2'b01; req_dir = 2'b01; req_long = 2'b00;
    tick();
    chk("t2_rdy", 32'(req_ready), 32'h1);
    chk("t2_h0", 32'(h_bridge), 32'h0);
    chk("t2_busy", 32'(busy), 32'd1);
    req_valid = 2'b00; req_dir = 2'b00; req_long = 2'b01;
    tick();
    hold("t2_brake", 3, 4'b0000, 1'b0);
    hold("t2_turn", 10, 4'b0101, 1'b0);
    hold("t2_settle", 3, 4'b0000, 1'b0);
    finish_done("t2", 4'b0110);

    // 3: both request together; requester 1 (left long) waits for the first manoeuvre
    req_valid = 2'b11; req_dir = 2'b01; req_long = 2'b10;
    tick();
    chk("t3_rdy0", 32'(req_ready), 32'h1);
    req_valid = 2'b10;
    tick();
    hold("t3a_brake", 3, 4'b0000, 1'b0);
    hold("t3a_turn", 10, 4'b0101, 1'b0);
    hold("t3a_settle", 3, 4'b0000, 1'b0);
    finish_done("t3a", 4'b0110);
    chk("t3_idle_rdy", 32'(req_ready), 32'h0);
    tick();
    chk("t3_rdy1", 32'(req_ready), 32'h2);
    chk("t3_rdy1_busy", 32'(busy), 32'd1);
    req_valid = 2'b00;
    tick();
    hold("t3b_brake", 3, 4'b0000, 1'b0);
    hold("t3b_turn", 20, 4'b1010, 1'b1);
    hold("t3b_settle", 3, 4'b0000, 1'b0);
    finish_done("t3b", 4'b0110);

    // 4: long left turn aborted on TURN cycle 5
    req_valid = 2'b01; req_dir = 2'b00; req_long = 2'b01;
    tick();
    chk("t4_rdy", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    tick();
    hold("t4_brake", 3, 4'b0000, 1'b0);
    hold("t4_turn", 4, 4'b1010, 1'b1);
    chk("t4_turn5_h", 32'(h_bridge), 32'hA);
    chk("t4_turn5_tl", 32'(turning_long), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    hold("t4_settle", 3, 4'b0000, 1'b0);
    finish_done("t4", 4'b0110);

    // 5: reset mid-TURN with the request still held; re-accepted on release
    req_valid = 2'b01; req_dir = 2'b01; req_long = 2'b00;
    tick();
    chk("t5_rdy", 32'(req_ready), 32'h1);
    tick();
    hold("t5_brake", 3, 4'b0000, 1'b0);
    hold("t5_turn", 2, 4'b0101, 1'b0);
    reset = 1'b0;
    tick();
    chk("t5_rst_h", 32'(h_bridge), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_done", 32'(turn_done), 32'd0);
    chk("t5_rst_tl", 32'(turning_long), 32'd0);
    reset = 1'b1;
    tick();
    chk("t5_reacc_rdy", 32'(req_ready), 32'h1);
    chk("t5_reacc_busy", 32'(busy), 32'd1);
    req_valid = 2'b00;
    tick();
    hold("t5_brake2", 3, 4'b0000, 1'b0);
    hold("t5_turn2", 10, 4'b0101, 1'b0);
    hold("t5_settle2", 3, 4'b0000, 1'b0);
    finish_done("t5", 4'b0110);

    // 6: turn_duty=0 blanks the turn only when PWM is built in
    turn_duty = 8'd0;
    req_valid = 2'b01; req_dir = 2'b01; req_long = 2'b00;
    tick();
    req_valid = 2'b00;
    tick();
    hold("t6_brake", 3, 4'b0000, 1'b0);
`ifdef TURN_PWM_EN
    hold("t6_turn_d0", 10, 4'b0000, 1'b0);
`else
    hold("t6_turn_full", 10, 4'b0101, 1'b0);
`endif
    hold("t6_settle", 3, 4'b0000, 1'b0);
    finish_done("t6", 4'b0110);

`ifdef TURN_PWM_EN
    // duty 3: pwm counter 0..2 on, 3..9 off
    turn_duty = 8'd3;
    req_valid = 2'b01; req_dir = 2'b01; req_long = 2'b00;
    tick();
    req_valid = 2'b00;
    tick();
    hold("t7_brake", 3, 4'b0000, 1'b0);
    hold("t7_on", 3, 4'b0101, 1'b0);
    hold("t7_off", 7, 4'b0000, 1'b0);
    hold("t7_settle", 3, 4'b0000, 1'b0);
    finish_done("t7", 4'b0110);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
